// File: rtl/dunit_ctrl.sv
// dunit_ctrl: host-link debug controller that loads, runs/steps and dumps the MIPS pipeline.
// Define DUNIT_MEM_DUMP_EN to append a data-memory dump after the register dump.
module dunit_ctrl #(
    parameter int NB_REG      = 32,
    parameter int NB_BYTE     = 8,
    parameter int N_REGS      = 32,
    parameter int RUN_TIMEOUT = 1024,
    parameter int MEM_WORDS   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    input  logic              i_halt,
    output logic              o_dunit_clk_en,
    output logic              o_dunit_reset_pc,
    output logic              o_dunit_w_mem,
    output logic [NB_REG-1:0] o_dunit_addr,
    output logic [NB_REG-1:0] o_dunit_data_if,
    input  logic [NB_REG-1:0] i_dunit_reg,
    input  logic [NB_REG-1:0] i_dunit_mem_data,
    output logic [3:0]        o_state
);

    localparam int BPW = NB_REG / NB_BYTE;
    localparam int BW  = $clog2(BPW);
    localparam int IW  = $clog2((N_REGS > MEM_WORDS) ? N_REGS : MEM_WORDS) + 1;

    localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);
    localparam logic [IW-1:0] LAST_REG  = IW'(N_REGS - 1);
    localparam logic [15:0]   RUN_LAST  = 16'(RUN_TIMEOUT - 1);

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_RPC  = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] ACK      = NB_BYTE'(8'h4B);
    localparam logic [NB_BYTE-1:0] ST_HALT  = NB_BYTE'(8'h48);
    localparam logic [NB_BYTE-1:0] ST_TMO   = NB_BYTE'(8'h54);
    localparam logic [NB_BYTE-1:0] ST_STEP  = NB_BYTE'(8'h53);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        LD_CNT      = 4'd1,
        LD_BYTE     = 4'd2,
        LD_WRITE    = 4'd3,
        RUN         = 4'd4,
        STEP        = 4'd5,
        DUMP_ADDR   = 4'd6,
        DUMP_WAIT   = 4'd7,
        DUMP_SEND   = 4'd8,
        SEND_ACK    = 4'd9,
        SEND_STATUS = 4'd10,
        RST_PC      = 4'd11
    } state_t;

    state_t              state;
    logic [NB_BYTE-1:0]  tx_data;
    logic                tx_valid;
    logic                clk_en;
    logic                reset_pc;
    logic                w_mem;
    logic [NB_REG-1:0]   addr;
    logic [NB_REG-1:0]   data_if;
    logic [NB_BYTE-1:0]  n_words;
    logic [NB_BYTE-1:0]  word_idx;
    logic [BW-1:0]       byte_idx;
    logic [15:0]         run_cnt;
    logic [IW-1:0]       dump_idx;
    logic [NB_REG-1:0]   dump_word;
    logic [NB_REG-1:0]   dump_src;
    logic                last_item;
    logic                more_mem;

`ifdef DUNIT_MEM_DUMP_EN
    localparam logic [IW-1:0] LAST_MEM = IW'(MEM_WORDS - 1);
    logic dump_mem;

    assign dump_src  = dump_mem ? i_dunit_mem_data : i_dunit_reg;
    assign last_item = dump_mem ? (dump_idx == LAST_MEM) : (dump_idx == LAST_REG);
    assign more_mem  = ~dump_mem;
`else
    logic unused_mem;

    assign dump_src   = i_dunit_reg;
    assign last_item  = (dump_idx == LAST_REG);
    assign more_mem   = 1'b0;
    assign unused_mem = ^i_dunit_mem_data;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            clk_en    <= 1'b0;
            reset_pc  <= 1'b0;
            w_mem     <= 1'b0;
            addr      <= '0;
            data_if   <= '0;
            n_words   <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            run_cnt   <= '0;
            dump_idx  <= '0;
            dump_word <= '0;
`ifdef DUNIT_MEM_DUMP_EN
            dump_mem  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                reset_pc <= 1'b1;
                                state    <= LD_CNT;
                            end
                            CMD_CONT: begin
                                clk_en  <= 1'b1;
                                run_cnt <= '0;
                                state   <= RUN;
                            end
                            CMD_STEP: begin
                                clk_en <= 1'b1;
                                state  <= STEP;
                            end
                            CMD_RPC: begin
                                reset_pc <= 1'b1;
                                state    <= RST_PC;
                            end
                            default: ;
                        endcase
                    end
                end
                RST_PC: begin
                    reset_pc <= 1'b0;
                    tx_data  <= ACK;
                    tx_valid <= 1'b1;
                    state    <= SEND_ACK;
                end
                LD_CNT: begin
                    if (i_rx_valid) begin
                        n_words  <= i_rx_data;
                        word_idx <= '0;
                        byte_idx <= '0;
                        if (i_rx_data == '0) begin
                            reset_pc <= 1'b0;
                            tx_data  <= ACK;
                            tx_valid <= 1'b1;
                            state    <= SEND_ACK;
                        end else begin
                            state <= LD_BYTE;
                        end
                    end
                end
                LD_BYTE: begin
                    if (i_rx_valid) begin
                        data_if <= {data_if[NB_REG-NB_BYTE-1:0], i_rx_data};
                        if (byte_idx == LAST_BYTE) begin
                            w_mem <= 1'b1;
                            addr  <= NB_REG'({word_idx, 2'b00});
                            state <= LD_WRITE;
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                        end
                    end
                end
                LD_WRITE: begin
                    w_mem <= 1'b0;
                    if (word_idx == n_words - NB_BYTE'(1)) begin
                        reset_pc <= 1'b0;
                        tx_data  <= ACK;
                        tx_valid <= 1'b1;
                        state    <= SEND_ACK;
                    end else begin
                        word_idx <= word_idx + NB_BYTE'(1);
                        byte_idx <= '0;
                        state    <= LD_BYTE;
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        clk_en   <= 1'b0;
                        tx_data  <= ST_HALT;
                        tx_valid <= 1'b1;
                        state    <= SEND_STATUS;
                    end else if (run_cnt == RUN_LAST) begin
                        clk_en   <= 1'b0;
                        tx_data  <= ST_TMO;
                        tx_valid <= 1'b1;
                        state    <= SEND_STATUS;
                    end else begin
                        run_cnt <= run_cnt + 16'd1;
                    end
                end
                STEP: begin
                    clk_en   <= 1'b0;
                    tx_data  <= ST_STEP;
                    tx_valid <= 1'b1;
                    state    <= SEND_STATUS;
                end
                SEND_ACK: begin
                    if (i_tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                SEND_STATUS: begin
                    if (i_tx_ready) begin
                        tx_valid <= 1'b0;
                        dump_idx <= '0;
                        addr     <= '0;
`ifdef DUNIT_MEM_DUMP_EN
                        dump_mem <= 1'b0;
`endif
                        state    <= DUMP_ADDR;
                    end
                end
                DUMP_ADDR: state <= DUMP_WAIT;
                DUMP_WAIT: begin
                    dump_word <= dump_src;
                    tx_data   <= dump_src[NB_REG-1 -: NB_BYTE];
                    tx_valid  <= 1'b1;
                    byte_idx  <= '0;
                    state     <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    // bytes go out back-to-back; dump_word shifts so the next byte is always at the top
                    if (i_tx_ready) begin
                        if (byte_idx == LAST_BYTE) begin
                            tx_valid <= 1'b0;
                            if (!last_item) begin
                                dump_idx <= dump_idx + IW'(1);
                                addr     <= NB_REG'(dump_idx + IW'(1));
                                state    <= DUMP_ADDR;
                            end else if (more_mem) begin
                                dump_idx <= '0;
                                addr     <= '0;
`ifdef DUNIT_MEM_DUMP_EN
                                dump_mem <= 1'b1;
`endif
                                state    <= DUMP_ADDR;
                            end else begin
                                addr  <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            byte_idx  <= byte_idx + BW'(1);
                            tx_data   <= dump_word[NB_REG-NB_BYTE-1 -: NB_BYTE];
                            dump_word <= dump_word << NB_BYTE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // halt must stop the pipeline in the very cycle it is observed, so it gates the registered enable
    assign o_dunit_clk_en   = clk_en & ~((state == RUN) & i_halt);
    assign o_tx_data        = tx_data;
    assign o_tx_valid       = tx_valid;
    assign o_dunit_reset_pc = reset_pc;
    assign o_dunit_w_mem    = w_mem;
    assign o_dunit_addr     = addr;
    assign o_dunit_data_if  = data_if;
    assign o_state          = state;

endmodule
